// File: rtl/qsys_system_time_set_ctrl.sv
// Front-panel time-setting controller: debounced MODE/ADVANCE buttons drive a
// RUN/SET_HOUR/SET_MIN sequencer with auto-repeat, exposed over an Avalon-MM slave.
module qsys_system_time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  in_port,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_min,
    output logic        load,
    output logic [1:0]  mode
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PER_M1 = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       w_db;
    logic [1:0]       r_db_q;
    logic [1:0]       w_press;
    logic             w_wr;
    logic             w_rd;
    logic             w_abort;
    logic             w_trans;
    logic             w_commit;
    logic             w_hold;
    logic             w_step;
    logic             r_rpt_act;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [4:0]       r_hour;
    logic [5:0]       r_min;
    logic             r_load;
    logic [1:0]       r_irq_mask;
    logic [1:0]       r_event;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db_q  <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_db_q  <= w_db;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_debounce
        logic             r_db_bit;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_db_bit <= 1'b1;
                r_cnt    <= '0;
            end else if (r_sync2[g] == r_db_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_db_bit <= r_sync2[g];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end

        assign w_db[g] = r_db_bit;
    end

    assign w_press = r_db_q & ~w_db;
    assign w_wr    = chipselect & ~write_n;
    assign w_rd    = chipselect & write_n;
    assign w_abort = w_wr && (address == 2'd0) && writedata[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_RUN;
        else          r_state <= w_next_state;
    end

    // Abort outranks a MODE press; a MODE press suppresses any ADVANCE step that cycle.
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = ST_RUN;
        end else if (w_press[0]) begin
            case (r_state)
                ST_RUN:      w_next_state = ST_SET_HOUR;
                ST_SET_HOUR: w_next_state = ST_SET_MIN;
                default:     w_next_state = ST_RUN;
            endcase
        end
        w_trans  = (w_next_state != r_state);
        w_commit = (r_state == ST_SET_MIN) && w_press[0] && !w_abort;
        w_hold   = (r_state != ST_RUN) && !w_trans && !w_db[1];
        w_step   = w_hold && (w_press[1] || (r_rpt_act && (r_rpt_cnt == '0)));
    end

    // Countdown to the next repeat step; armed only by a press inside a SET state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rpt_act <= 1'b0;
            r_rpt_cnt <= '0;
        end else if (!w_hold) begin
            r_rpt_act <= 1'b0;
            r_rpt_cnt <= '0;
        end else if (w_press[1]) begin
            r_rpt_act <= 1'b1;
            r_rpt_cnt <= RPT_DLY_M1;
        end else if (r_rpt_act) begin
            if (r_rpt_cnt == '0) r_rpt_cnt <= RPT_PER_M1;
            else                 r_rpt_cnt <= r_rpt_cnt - CNT_ONE;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0: w_rdata[1:0] = r_state;
            2'd1: begin
                w_rdata[12:8] = r_hour;
                w_rdata[5:0]  = r_min;
            end
            2'd2: w_rdata[1:0] = r_irq_mask;
            default: w_rdata[1:0] = r_event;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hour     <= '0;
            r_min      <= '0;
            r_load     <= 1'b0;
            r_irq_mask <= '0;
            r_event    <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr && (address == 2'd1) && (r_state == ST_RUN)) begin
                r_hour <= (writedata[12:8] > 5'd23) ? '0 : writedata[12:8];
                r_min  <= (writedata[5:0] > 6'd59) ? '0 : writedata[5:0];
            end else if (w_step) begin
                if (r_state == ST_SET_HOUR) r_hour <= (r_hour == 5'd23) ? '0 : r_hour + 5'd1;
                else                        r_min  <= (r_min == 6'd59) ? '0 : r_min + 6'd1;
            end
            if (w_wr && (address == 2'd2)) r_irq_mask <= writedata[1:0];
            r_event    <= ((w_wr && (address == 2'd3)) ? 2'b00 : r_event) | {w_trans, w_commit};
            r_load     <= w_commit;
            r_readdata <= w_rd ? w_rdata : '0;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_event & r_irq_mask);
    assign set_hour = r_hour;
    assign set_min  = r_min;
    assign load     = r_load;
    assign mode     = r_state;

endmodule

// File: tb/tb_qsys_system_time_set_ctrl.sv
// Directed bench for qsys_system_time_set_ctrl: a cycle-level behavioural model is
// compared against every output on each falling clock edge, plus literal spot checks.
module tb_qsys_system_time_set_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [1:0]  in_port    = 2'b11;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [4:0]  set_hour;
    logic [5:0]  set_min;
    logic        load;
    logic [1:0]  mode;

    int n_tests  = 0;
    int n_fail   = 0;
    int load_cnt = 0;

    qsys_system_time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (25)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .load      (load),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state; m_h counts held cycles since the ADVANCE press (-1 = idle).
    int m_s1[2]  = '{1, 1};
    int m_s2[2]  = '{1, 1};
    int m_db[2]  = '{1, 1};
    int m_dbq[2] = '{1, 1};
    int m_run[2] = '{0, 0};
    int m_mode = 0, m_hour = 0, m_min = 0, m_load = 0;
    int m_mask = 0, m_event = 0, m_rd = 0, m_h = -1;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1; m_s2[i] = 1; m_db[i] = 1; m_dbq[i] = 1; m_run[i] = 0;
        end
        m_mode = 0; m_hour = 0; m_min = 0; m_load = 0;
        m_mask = 0; m_event = 0; m_rd = 0; m_h = -1;
    endtask

    task automatic model_step();
        int wr, rd, p0, p1, abort, nm, chg, commit, step, newh, nh, nmin, nev, nrd, wh, wm;
        wr    = (chipselect && !write_n) ? 1 : 0;
        rd    = (chipselect && write_n) ? 1 : 0;
        p0    = (m_dbq[0] == 1 && m_db[0] == 0) ? 1 : 0;
        p1    = (m_dbq[1] == 1 && m_db[1] == 0) ? 1 : 0;
        abort = (wr == 1 && address == 2'd0 && writedata[0]) ? 1 : 0;
        nm = m_mode;
        if (abort == 1)   nm = 0;
        else if (p0 == 1) nm = (m_mode + 1) % 3;
        chg    = (nm != m_mode) ? 1 : 0;
        commit = (p0 == 1 && abort == 0 && m_mode == 2) ? 1 : 0;
        step = 0;
        newh = -1;
        if (chg == 0 && m_mode != 0 && m_db[1] == 0) begin
            if (p1 == 1) begin
                step = 1;
                newh = 1;
            end else if (m_h >= 0) begin
                step = (m_h >= RD && (m_h - RD) % RP == 0) ? 1 : 0;
                newh = m_h + 1;
            end
        end
        nh = m_hour;
        nmin = m_min;
        if (wr == 1 && address == 2'd1 && m_mode == 0) begin
            wh = int'(writedata[12:8]);
            wm = int'(writedata[5:0]);
            nh   = (wh > 23) ? 0 : wh;
            nmin = (wm > 59) ? 0 : wm;
        end else if (step == 1) begin
            if (m_mode == 1) nh = (m_hour + 1) % 24;
            else             nmin = (m_min + 1) % 60;
        end
        nev = (wr == 1 && address == 2'd3) ? 0 : m_event;
        nev = nev | (chg * 2) | commit;
        nrd = 0;
        if (rd == 1) begin
            case (address)
                2'd0: nrd = m_mode;
                2'd1: nrd = m_hour * 256 + m_min;
                2'd2: nrd = m_mask;
                default: nrd = m_event;
            endcase
        end
        if (wr == 1 && address == 2'd2) m_mask = int'(writedata[1:0]);
        for (int i = 0; i < 2; i++) begin
            m_dbq[i] = m_db[i];
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(in_port[i]);
        end
        m_mode = nm; m_hour = nh; m_min = nmin; m_event = nev;
        m_load = commit; m_rd = nrd; m_h = newh;
    endtask

    always @(negedge reset_n) model_reset();

    always @(posedge clk) if (reset_n) model_step();

    always @(negedge clk) begin
        check("readdata", int'(readdata), m_rd);
        check("irq", int'(irq), ((m_event & m_mask) != 0) ? 1 : 0);
        check("set_hour", int'(set_hour), m_hour);
        check("set_min", int'(set_min), m_min);
        check("load", int'(load), m_load);
        check("mode", int'(mode), m_mode);
        if (load) load_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic avwrite(input int a, input int d);
        address = 2'(a); writedata = 32'(d); chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic avread(input int a, output int d);
        address = 2'(a); chipselect = 1'b1; write_n = 1'b1;
        tick(1);
        d = int'(readdata);
        chipselect = 1'b0;
    endtask

    task automatic press(input int b);
        in_port[b] = 1'b0;
        tick(10);
        in_port[b] = 1'b1;
        tick(10);
    endtask

    initial begin
        int d;
        #1 reset_n = 1'b0;
        tick(3);
        check("rst_mode", int'(mode), 0);
        check("rst_readdata", int'(readdata), 0);
        check("rst_load", int'(load), 0);
        check("rst_irq", int'(irq), 0);
        reset_n = 1'b1;
        tick(3);

        // Bounce: 2-cycle glitches never survive debounce, the final hold gives one press.
        for (int k = 0; k < 10; k++) begin
            in_port[0] = ~in_port[0];
            tick(2);
        end
        press(0);
        check("bounce_mode", int'(mode), 1);
        avread(3, d);
        check("bounce_event", d, 2);

        avwrite(0, 1);
        avwrite(3, 0);
        avwrite(1, (22 << 8) | 58);
        press(0);
        repeat (3) press(1);
        press(0);
        repeat (2) press(1);
        // Final MODE press with an event clear sampled on the commit edge.
        in_port[0] = 1'b0;
        tick(6);
        avwrite(3, 0);
        tick(3);
        in_port[0] = 1'b1;
        tick(10);
        check("session_hour", int'(set_hour), 1);
        check("session_min", int'(set_min), 0);
        check("session_mode", int'(mode), 0);
        check("session_loads", load_cnt, 1);
        avread(3, d);
        check("session_event", d, 3);
        avwrite(2, 1);
        check("session_irq", int'(irq), 1);

        press(0);
        press(0);
        in_port[1] = 1'b0;
        tick(43);
        in_port[1] = 1'b1;
        tick(10);
        check("repeat_min", int'(set_min), 6);
        check("repeat_hour", int'(set_hour), 1);

        press(0);
        check("commit2_loads", load_cnt, 2);
        press(0);
        in_port = 2'b00;
        tick(10);
        in_port = 2'b11;
        tick(10);
        check("simul_mode", int'(mode), 2);
        check("simul_hour", int'(set_hour), 1);
        check("simul_min", int'(set_min), 6);
        in_port[0] = 1'b0;
        tick(6);
        avwrite(0, 1);
        tick(3);
        in_port[0] = 1'b1;
        tick(10);
        check("abort_mode", int'(mode), 0);
        check("abort_loads", load_cnt, 2);

        press(0);
        avwrite(1, (5 << 8) | 5);
        avread(1, d);
        check("seed_in_set", d, (1 << 8) | 6);
        avwrite(0, 1);
        avwrite(1, (30 << 8) | 10);
        avread(1, d);
        check("clamp_hour", d, 10);
        avwrite(1, (3 << 8) | 60);
        avread(1, d);
        check("clamp_min", d, 3 << 8);
        avread(2, d);
        check("mask_read", d, 1);

        avwrite(1, (3 << 8) | 17);
        press(0);
        press(0);
        check("pre_rst_mode", int'(mode), 2);
        check("pre_rst_min", int'(set_min), 17);
        reset_n = 1'b0;
        #1;
        check("arst_mode", int'(mode), 0);
        check("arst_min", int'(set_min), 0);
        check("arst_hour", int'(set_hour), 0);
        check("arst_load", int'(load), 0);
        check("arst_irq", int'(irq), 0);
        check("arst_readdata", int'(readdata), 0);
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("arst_loads", load_cnt, 2);
        avread(2, d);
        check("arst_mask", d, 0);
        avread(3, d);
        check("arst_event", d, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
